// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter: shift mode encodings and FSM states.
package shift_pkg;

    localparam logic [2:0] MODE_LSL  = 3'b000;
    localparam logic [2:0] MODE_LSR  = 3'b001;
    localparam logic [2:0] MODE_ASR  = 3'b010;
    localparam logic [2:0] MODE_ASL  = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_LAST = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } shift_arb_state_t;

    function automatic logic mode_is_legal(input logic [2:0] mode);
        return mode <= MODE_LAST;
    endfunction

endpackage

// File: rtl/shift_arbiter_shift.sv
// Combinational barrel shifter (module shift). cout is the last bit shifted out (0 for count 0);
// overflow is only set by ASL when the sign cannot be preserved; illegal modes pass x through.
module shift
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [SW-1:0]    count_i,
    input  logic [2:0]       mode_i,
    output logic [WIDTH-1:0] y_o,
    output logic             negative_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             err_o
);

    logic [WIDTH:0]          leftWide;
    logic [WIDTH:0]          rightWide;
    logic [WIDTH:0]          asrWide;
    logic [2*WIDTH-1:0]      rotWide;
    logic signed [WIDTH-1:0] aslBack;

    always_comb begin
        leftWide  = {1'b0, x_i} << count_i;
        rightWide = {x_i, 1'b0} >> count_i;
        asrWide   = $signed({x_i, 1'b0}) >>> count_i;
        rotWide   = {x_i, x_i} >> count_i;
        // Shifting the ASL result back must reproduce x, otherwise significant bits were lost.
        aslBack   = $signed(leftWide[WIDTH-1:0]) >>> count_i;
    end

    always_comb begin
        y_o        = x_i;
        cout_o     = 1'b0;
        overflow_o = 1'b0;
        err_o      = 1'b0;
        case (mode_i)
            MODE_LSL: begin
                y_o    = leftWide[WIDTH-1:0];
                cout_o = leftWide[WIDTH];
            end
            MODE_ASL: begin
                y_o        = leftWide[WIDTH-1:0];
                cout_o     = leftWide[WIDTH];
                overflow_o = (aslBack != $signed(x_i));
            end
            MODE_LSR: begin
                y_o    = rightWide[WIDTH:1];
                cout_o = rightWide[0];
            end
            MODE_ASR: begin
                y_o    = asrWide[WIDTH:1];
                cout_o = asrWide[0];
            end
            MODE_ROR: begin
                y_o    = rotWide[WIDTH-1:0];
                cout_o = (|count_i) & rotWide[WIDTH-1];
            end
            default: begin
                y_o   = x_i;
                err_o = 1'b1;
            end
        endcase
        negative_o = ~err_o & y_o[WIDTH-1];
        zero_o     = ~err_o & (y_o == '0);
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shift unit between two requesters (IDLE -> EXEC -> RESP).
// Optional grant counters with stat_clear are built when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SHIFT_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [WIDTH-1:0]       req_x_0,
    input  logic [WIDTH-1:0]       req_x_1,
    input  logic [SHIFT_WIDTH-1:0] req_count_0,
    input  logic [SHIFT_WIDTH-1:0] req_count_1,
    input  logic [2:0]             req_mode_0,
    input  logic [2:0]             req_mode_1,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [WIDTH-1:0]       rsp_y,
    output logic                   rsp_negative,
    output logic                   rsp_zero,
    output logic                   rsp_cout,
    output logic                   rsp_overflow,
    output logic                   rsp_err
`ifdef SHIFT_ARB_STATS_EN
    ,
    input  logic                   stat_clear,
    output logic [15:0]            stat_grants_0,
    output logic [15:0]            stat_grants_1
`endif
);

    shift_arb_state_t state_q, state_d;
    logic             ptr_q, ptr_d;

    logic [WIDTH-1:0]       opX_q;
    logic [SHIFT_WIDTH-1:0] opCount_q;
    logic [2:0]             opMode_q;
    logic                   opId_q;

    logic [WIDTH-1:0] rspY_q;
    logic             rspNeg_q, rspZero_q, rspCout_q, rspOv_q, rspErr_q, rspId_q;

    logic             grantId;
    logic             accept;
    logic             rspDone;

    logic [WIDTH-1:0] shY;
    logic             shNeg, shZero, shCout, shOv, shErr;

    // The pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        grantId   = 1'b0;
        accept    = 1'b0;
        req_ready = 2'b00;
        if (req_valid == 2'b11) begin
            grantId = ptr_q;
        end else begin
            grantId = req_valid[1];
        end
        if (state_q == IDLE && req_valid != 2'b00) begin
            accept    = 1'b1;
            req_ready = grantId ? 2'b10 : 2'b01;
        end
    end

    assign rspDone = (state_q == RESP) && rsp_ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: if (accept) state_d = EXEC;
            EXEC: state_d = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    ptr_d   = ~rspId_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            opX_q     <= '0;
            opCount_q <= '0;
            opMode_q  <= '0;
            opId_q    <= 1'b0;
            rspY_q    <= '0;
            rspNeg_q  <= 1'b0;
            rspZero_q <= 1'b0;
            rspCout_q <= 1'b0;
            rspOv_q   <= 1'b0;
            rspErr_q  <= 1'b0;
            rspId_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (accept) begin
                opId_q    <= grantId;
                opX_q     <= grantId ? req_x_1 : req_x_0;
                opCount_q <= grantId ? req_count_1 : req_count_0;
                opMode_q  <= grantId ? req_mode_1 : req_mode_0;
            end
            if (state_q == EXEC) begin
                rspY_q    <= shY;
                rspNeg_q  <= shNeg;
                rspZero_q <= shZero;
                rspCout_q <= shCout;
                rspOv_q   <= shOv;
                rspErr_q  <= shErr;
                rspId_q   <= opId_q;
            end else if (rspDone) begin
                rspErr_q <= 1'b0;
            end
        end
    end

    shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .x_i        (opX_q),
        .count_i    (opCount_q),
        .mode_i     (opMode_q),
        .y_o        (shY),
        .negative_o (shNeg),
        .zero_o     (shZero),
        .cout_o     (shCout),
        .overflow_o (shOv),
        .err_o      (shErr)
    );

    assign rsp_valid    = (state_q == RESP);
    assign rsp_id       = rspId_q;
    assign rsp_y        = rspY_q;
    assign rsp_negative = rspNeg_q;
    assign rsp_zero     = rspZero_q;
    assign rsp_cout     = rspCout_q;
    assign rsp_overflow = rspOv_q;
    assign rsp_err      = rspErr_q;

`ifdef SHIFT_ARB_STATS_EN
    logic [15:0] statGrants0_q, statGrants1_q;

    // Clear beats a same-cycle grant; counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || stat_clear) begin
            statGrants0_q <= '0;
            statGrants1_q <= '0;
        end else begin
            if (accept && !grantId && statGrants0_q != 16'hFFFF) begin
                statGrants0_q <= statGrants0_q + 16'd1;
            end
            if (accept && grantId && statGrants1_q != 16'hFFFF) begin
                statGrants1_q <= statGrants1_q + 16'd1;
            end
        end
    end

    assign stat_grants_0 = statGrants0_q;
    assign stat_grants_1 = statGrants1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized traffic
// compared against a bit-serial shift model and a tie-break pointer model.
module tb_shift_arbiter;

    localparam int W  = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN;
    logic [1:0]    reqValid;
    logic [1:0]    reqReady;
    logic [W-1:0]  x0, x1;
    logic [SW-1:0] c0, c1;
    logic [2:0]    m0, m1;
    logic          rspValid, rspReady, rspId;
    logic [W-1:0]  rspY;
    logic          rspNeg, rspZero, rspCout, rspOv, rspErr;
`ifdef SHIFT_ARB_STATS_EN
    logic          statClear;
    logic [15:0]   statG0, statG1;
`endif

    int   nVectors     = 0;
    int   nMiscompares = 0;
    logic modelPtr     = 1'b0;

    shift_arbiter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rstN),
        .req_valid    (reqValid),
        .req_ready    (reqReady),
        .req_x_0      (x0),
        .req_x_1      (x1),
        .req_count_0  (c0),
        .req_count_1  (c1),
        .req_mode_0   (m0),
        .req_mode_1   (m1),
        .rsp_valid    (rspValid),
        .rsp_ready    (rspReady),
        .rsp_id       (rspId),
        .rsp_y        (rspY),
        .rsp_negative (rspNeg),
        .rsp_zero     (rspZero),
        .rsp_cout     (rspCout),
        .rsp_overflow (rspOv),
        .rsp_err      (rspErr)
`ifdef SHIFT_ARB_STATS_EN
        ,
        .stat_clear    (statClear),
        .stat_grants_0 (statG0),
        .stat_grants_1 (statG1)
`endif
    );

    // Reference: shift one bit at a time; returns {y, negative, zero, cout, overflow, err}.
    function automatic logic [W+4:0] refShift(input logic [W-1:0] x, input int c, input logic [2:0] m);
        logic [W-1:0] y;
        logic co;
        logic ov;
        y  = x;
        co = 1'b0;
        ov = 1'b0;
        if (m > 3'd4) return {x, 5'b00001};
        for (int k = 0; k < c; k++) begin
            case (m)
                3'd0, 3'd3: begin
                    if (y[W-1] != y[W-2]) ov = 1'b1;
                    co = y[W-1];
                    y  = {y[W-2:0], 1'b0};
                end
                3'd1: begin
                    co = y[0];
                    y  = {1'b0, y[W-1:1]};
                end
                3'd2: begin
                    co = y[0];
                    y  = {y[W-1], y[W-1:1]};
                end
                default: begin
                    y  = {y[0], y[W-1:1]};
                    co = y[W-1];
                end
            endcase
        end
        if (m != 3'd3) ov = 1'b0;
        return {y, y[W-1], (y == '0), co, ov, 1'b0};
    endfunction

    function automatic logic [W+4:0] observed();
        return {rspY, rspNeg, rspZero, rspCout, rspOv, rspErr};
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rstN     = 1'b0;
        reqValid = 2'b00;
        rspReady = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN     = 1'b1;
        modelPtr = 1'b0;
    endtask

    // Presents a request and waits for the accept edge; returns 1 ns after that edge.
    task automatic issueReq(input logic [1:0] valid, output logic acceptedId, output bit timedOut);
        bit found;
        found      = 1'b0;
        acceptedId = 1'b0;
        @(negedge clk);
        reqValid = valid;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (reqReady != 2'b00) begin
                acceptedId = reqReady[1];
                found      = 1'b1;
            end
            @(posedge clk);
            #1;
            if (!found) @(negedge clk);
        end
        reqValid = 2'b00;
        timedOut = !found;
    endtask

    task automatic waitRsp(output int lat, output bit timedOut);
        lat      = 0;
        timedOut = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (rspValid) begin
                timedOut = 1'b0;
                break;
            end
        end
    endtask

    task automatic finishRsp(input logic expId);
        rspReady = 1'b1;
        @(posedge clk);
        #1;
        rspReady = 1'b0;
        modelPtr = ~expId;
    endtask

    task automatic test_reset();
        logic [W+10:0] obs;
        applyReset();
        rstN = 1'b0;
        @(posedge clk);
        @(negedge clk);
        obs = {reqReady, rspValid, rspId, rspY, rspNeg, rspZero, rspCout, rspOv, rspErr};
        nVectors++;
        if (obs !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_outputs got %h want 0", obs);
        end
`ifdef SHIFT_ARB_STATS_EN
        nVectors++;
        if ({statG0, statG1} !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL reset_stats got %h want 0", {statG0, statG1});
        end
`endif
        rstN = 1'b1;
    endtask

    task automatic test_ror();
        logic acc;
        bit   to;
        int   lat;
        applyReset();
        x0 = 16'h8001; c0 = 4'd1; m0 = 3'b100;
        issueReq(2'b01, acc, to);
        nVectors++;
        if (to || acc !== 1'b0) begin
            nMiscompares++;
            $display("[TB] FAIL ror_accept got id=%0d timeout=%0d want id=0", acc, to);
        end
        waitRsp(lat, to);
        nVectors++;
        if (to || lat != 2) begin
            nMiscompares++;
            $display("[TB] FAIL ror_latency got %0d want 2", lat);
        end
        nVectors++;
        if ({rspId, rspY, rspNeg, rspZero} !== {1'b0, 16'hC000, 1'b1, 1'b0}) begin
            nMiscompares++;
            $display("[TB] FAIL ror_result got id=%0d y=%h n=%0d z=%0d want id=0 y=c000 n=1 z=0",
                     rspId, rspY, rspNeg, rspZero);
        end
        nVectors++;
        if (observed() !== refShift(16'h8001, 1, 3'b100)) begin
            nMiscompares++;
            $display("[TB] FAIL ror_flags got %h want %h", observed(), refShift(16'h8001, 1, 3'b100));
        end
        finishRsp(1'b0);
    endtask

    task automatic test_round_robin();
        logic       acc;
        bit         to;
        int         lat;
        logic       expId [3];
        logic [W-1:0] expY [3];
        expId = '{1'b0, 1'b1, 1'b0};
        expY  = '{16'h0010, 16'hFFFF, 16'h0010};
        applyReset();
        x0 = 16'h0001; c0 = 4'd4;  m0 = 3'b000;
        x1 = 16'h8000; c1 = 4'd15; m1 = 3'b010;
        for (int r = 0; r < 3; r++) begin
            issueReq(2'b11, acc, to);
            waitRsp(lat, to);
            nVectors++;
            if (to || {acc, rspId, rspY} !== {expId[r], expId[r], expY[r]}) begin
                nMiscompares++;
                $display("[TB] FAIL rr_round%0d got acc=%0d id=%0d y=%h want id=%0d y=%h",
                         r, acc, rspId, rspY, expId[r], expY[r]);
            end
            finishRsp(expId[r]);
        end
    endtask

    task automatic test_back_to_back();
        logic acc;
        bit   to;
        int   lat;
        applyReset();
        x1 = 16'h00F0; c1 = 4'd4; m1 = 3'b001;
        for (int r = 0; r < 2; r++) begin
            issueReq(2'b10, acc, to);
            waitRsp(lat, to);
            nVectors++;
            if (to || {acc, rspId, rspY} !== {1'b1, 1'b1, 16'h000F}) begin
                nMiscompares++;
                $display("[TB] FAIL b2b_round%0d got acc=%0d id=%0d y=%h want id=1 y=000f",
                         r, acc, rspId, rspY);
            end
            finishRsp(1'b1);
        end
    endtask

    task automatic test_backpressure();
        logic          acc;
        bit            to;
        int            lat;
        logic [W+4:0]  exp;
        x1 = 16'h4321; c1 = 4'd3; m1 = 3'b011;
        exp = refShift(16'h4321, 3, 3'b011);
        issueReq(2'b10, acc, to);
        waitRsp(lat, to);
        reqValid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            nVectors++;
            if (to || {rspValid, rspId, reqReady, observed()} !== {1'b1, 1'b1, 2'b00, exp}) begin
                nMiscompares++;
                $display("[TB] FAIL hold_cycle%0d got v=%0d id=%0d rdy=%b r=%h want v=1 id=1 rdy=00 r=%h",
                         i, rspValid, rspId, reqReady, observed(), exp);
            end
            @(negedge clk);
        end
        finishRsp(1'b1);
        nVectors++;
        if ({rspValid, reqReady} !== {1'b0, 2'b01}) begin
            nMiscompares++;
            $display("[TB] FAIL hold_release got v=%0d rdy=%b want v=0 rdy=01", rspValid, reqReady);
        end
        reqValid = 2'b00;
    endtask

    task automatic test_illegal();
        logic acc;
        bit   to;
        int   lat;
        applyReset();
        x0 = 16'h1234; c0 = 4'd5; m0 = 3'b111;
        issueReq(2'b01, acc, to);
        waitRsp(lat, to);
        nVectors++;
        if (to || observed() !== {16'h1234, 5'b00001}) begin
            nMiscompares++;
            $display("[TB] FAIL illegal_mode got %h want %h", observed(), {16'h1234, 5'b00001});
        end
        finishRsp(1'b0);
        x0 = 16'h1234; c0 = 4'd0; m0 = 3'b000;
        issueReq(2'b01, acc, to);
        waitRsp(lat, to);
        nVectors++;
        if (to || observed() !== {16'h1234, 5'b00000}) begin
            nMiscompares++;
            $display("[TB] FAIL illegal_recover got %h want %h", observed(), {16'h1234, 5'b00000});
        end
        finishRsp(1'b0);
    endtask

    task automatic test_reset_mid_exec();
        logic          acc;
        bit            to;
        int            lat;
        logic [W+10:0] obs;
        applyReset();
        x0 = 16'h0003; c0 = 4'd1; m0 = 3'b000;
        issueReq(2'b01, acc, to);
        waitRsp(lat, to);
        finishRsp(1'b0);
        x1 = 16'h00FF; c1 = 4'd2; m1 = 3'b000;
        issueReq(2'b10, acc, to);
        rstN = 1'b0;
        @(posedge clk);
        #1;
        obs = {reqReady, rspValid, rspId, rspY, rspNeg, rspZero, rspCout, rspOv, rspErr};
        nVectors++;
        if (obs !== '0) begin
            nMiscompares++;
            $display("[TB] FAIL kill_outputs got %h want 0", obs);
        end
        @(negedge clk);
        rstN     = 1'b1;
        modelPtr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            nVectors++;
            if (rspValid !== 1'b0) begin
                nMiscompares++;
                $display("[TB] FAIL kill_no_rsp cycle%0d got v=%0d want v=0", i, rspValid);
            end
        end
        reqValid = 2'b11;
        #1;
        nVectors++;
        if (reqReady !== 2'b01) begin
            nMiscompares++;
            $display("[TB] FAIL kill_pointer got rdy=%b want 01", reqReady);
        end
        reqValid = 2'b00;
    endtask

    task automatic test_random();
        logic          acc;
        logic          expWin;
        bit            to;
        int            lat;
        logic [1:0]    valid;
        logic [W+4:0]  exp;
        applyReset();
        for (int n = 0; n < 40; n++) begin
            valid  = 2'($urandom_range(1, 3));
            x0     = 16'($urandom);
            x1     = 16'($urandom);
            c0     = 4'($urandom_range(0, 15));
            c1     = 4'($urandom_range(0, 15));
            m0     = 3'($urandom_range(0, 7));
            m1     = 3'($urandom_range(0, 7));
            expWin = (valid == 2'b11) ? modelPtr : valid[1];
            exp    = expWin ? refShift(x1, int'(c1), m1) : refShift(x0, int'(c0), m0);
            issueReq(valid, acc, to);
            nVectors++;
            if (to || acc !== expWin) begin
                nMiscompares++;
                $display("[TB] FAIL rnd%0d_grant got %0d timeout=%0d want %0d", n, acc, to, expWin);
            end
            waitRsp(lat, to);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            nVectors++;
            if (to || lat != 2 || {rspValid, rspId, observed()} !== {1'b1, expWin, exp}) begin
                nMiscompares++;
                $display("[TB] FAIL rnd%0d_rsp got lat=%0d v=%0d id=%0d r=%h want lat=2 v=1 id=%0d r=%h",
                         n, lat, rspValid, rspId, observed(), expWin, exp);
            end
            finishRsp(expWin);
        end
    endtask

`ifdef SHIFT_ARB_STATS_EN
    task automatic test_stats();
        logic acc;
        bit   to;
        int   lat;
        logic ids [4];
        ids = '{1'b0, 1'b1, 1'b0, 1'b0};
        applyReset();
        statClear = 1'b0;
        foreach (ids[k]) begin
            issueReq(ids[k] ? 2'b10 : 2'b01, acc, to);
            waitRsp(lat, to);
            finishRsp(ids[k]);
        end
        nVectors++;
        if ({statG0, statG1} !== {16'd3, 16'd1}) begin
            nMiscompares++;
            $display("[TB] FAIL stats_count got %0d/%0d want 3/1", statG0, statG1);
        end
        @(negedge clk);
        statClear = 1'b1;
        reqValid  = 2'b01;
        @(posedge clk);
        #1;
        statClear = 1'b0;
        reqValid  = 2'b00;
        nVectors++;
        if ({statG0, statG1} !== 32'h0) begin
            nMiscompares++;
            $display("[TB] FAIL stats_clear got %0d/%0d want 0/0", statG0, statG1);
        end
        waitRsp(lat, to);
        finishRsp(1'b0);
    endtask
`endif

    initial begin
        rstN     = 1'b0;
        reqValid = 2'b00;
        rspReady = 1'b0;
        x0 = '0; x1 = '0; c0 = '0; c1 = '0; m0 = '0; m1 = '0;
`ifdef SHIFT_ARB_STATS_EN
        statClear = 1'b0;
`endif
        test_reset();
        test_ror();
        test_round_robin();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid_exec();
        test_random();
`ifdef SHIFT_ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational barrel shift unit between two requesters using round-robin arbitration. Each request carries an operand, a shift count and a mode, and uses a valid/ready handshake. The block captures the granted request, executes the shift, and registers the result and flags. It returns the response on a single valid/ready response channel tagged with the requester ID. It sits between the integer issue logic and the shift datapath in the ALU.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a power of two, ≥ 4.
- SHIFT_WIDTH, $clog2(WIDTH), shift-count width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester accept strobe; at most one bit high.
- req_x_0, req_x_1  in  WIDTH  operands.
- req_count_0, req_count_1  in  SHIFT_WIDTH  shift counts.
- req_mode_0, req_mode_1  in  3  mode: 000 LSL, 001 LSR, 010 ASR, 011 ASL, 100 ROR; 101–111 are illegal.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that issued the response.
- rsp_y  out  WIDTH  shift result.
- rsp_negative, rsp_zero, rsp_cout, rsp_overflow  out  1 each  registered flags from the shift unit.
- rsp_err  out  1  illegal mode.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state is IDLE and the priority pointer is 0.
  - req_ready, rsp_valid, rsp_id, rsp_y, all flags and rsp_err are 0.
  - Reset mid-operation discards the captured request silently, with no response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is driven combinationally to the winning requester only, and only if that requester's req_valid is high.
  - Winner when both are valid: the requester equal to the pointer. Otherwise the single valid requester wins.
  - On the handshake edge, capture x, count, mode and id into operand registers, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (1 cycle):
  - The shift unit is driven from the operand registers.
  - On the edge, load rsp_y and the flags from the shift unit, set rsp_id, and go to RESP.
  - For an illegal mode: rsp_y takes the captured x unchanged, rsp_err=1, and all four flags are 0.
- RESP:
  - rsp_valid=1.
  - All rsp_* outputs are held stable until rsp_ready is sampled high.
  - On the handshake edge: rsp_valid=0, rsp_err=0, the pointer becomes ~rsp_id, and the FSM goes to IDLE.
  - req_ready is 0 in EXEC and RESP, so there is no acceptance while a response is pending.
- Timing:
  - Latency: accept at edge T, rsp_valid high after edge T+1. The response is visible in the cycle after the shift executes, i.e. 2 cycles after acceptance.
  - Peak throughput: one operation per 3 cycles, since IDLE is mandatory between operations.
- Requester rules:
  - A requester may deassert req_valid before being accepted; no state changes in that case.
  - Request inputs are sampled only on the accept edge.
- Count of 0 executes normally and gives y = x.
- The pointer only toggles on a completed response; a lone requester may be served back-to-back.

Optional Feature:
- Macro: SHIFT_ARB_STATS_EN.
- When defined:
  - Adds outputs stat_grants_0 and stat_grants_1, 16 bits each.
  - Each counter increments on its requester's accept edge and saturates at 16'hFFFF.
  - Adds input stat_clear (1 bit), which synchronously zeroes both counters. Clear takes priority over a same-cycle increment.
  - Counters reset to 0 with rst_n.
- When undefined: these ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package shift_pkg holds:
  - mode constants MODE_LSL, MODE_LSR, MODE_ASR, MODE_ASL, MODE_ROR;
  - MODE_LAST = 3'b100, used for the legality check;
  - the FSM state typedef shift_arb_state_t (IDLE, EXEC, RESP).
- Sub-modules:
  - One instance of the team's existing combinational shift unit (module shift), parameterised with WIDTH.
  - The arbiter and FSM stay in this module; no further sub-module is needed.

Test Plan:
- Single request from requester 0 with x=16'h8001, count=1, mode=100 (ROR) → rsp_y=16'hC000, rsp_id=0, rsp_negative=1, rsp_zero=0. rsp_valid rises 2 cycles after accept.
- Both valid from reset (x0=16'h0001 LSL 4, x1=16'h8000 ASR 15), rsp_ready tied 1 → requester 0 served first (rsp_y=16'h0010), then requester 1 (rsp_y=16'hFFFF, rsp_id=1). A third round with both valid grants requester 0 again.
- rsp_ready held low 5 cycles during RESP → rsp_valid, rsp_y, flags and rsp_id stable throughout, and req_ready=2'b00 every cycle. Completes on the first cycle rsp_ready=1.
- Illegal mode 3'b111 with x=16'h1234 → rsp_err=1, rsp_y=16'h1234, all flags 0. The next legal request returns rsp_err=0.
- rst_n driven low during EXEC → next cycle rsp_valid=0 and all outputs 0. No response is ever produced for the killed request, and the pointer is back at 0.
- With SHIFT_ARB_STATS_EN: 3 grants to requester 0 and 1 grant to requester 1 → stat_grants_0=3, stat_grants_1=1. Asserting stat_clear zeroes both; a counter preloaded near 16'hFFFF saturates rather than wrapping.
